// File: rtl/riscv_pkg.sv
// Shared encodings for the MEM stage: funct3 access sizes, result-select codes
// and the data-memory responder FSM states.
package riscv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_DONE
  } dmem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } dmem_size_e;

  // Access size; the unused encodings 011/110/111 fall back to a word access.
  function automatic dmem_size_e dmem_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      F3_W:        return SZ_WORD;
      default:     return SZ_WORD;
    endcase
  endfunction

  function automatic logic dmem_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit memory word and the pipeline:
// store byte enables / lane replication, load lane select / extension,
// and alignment checking.
module dmem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        misalign
);

  dmem_size_e  size;
  logic        uns;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Decode size, then steer lanes for both directions.
  always_comb begin
    byte_en   = '0;
    wdata_rep = '0;
    rdata     = '0;
    misalign  = 1'b0;
    size      = dmem_size(funct3);
    uns       = dmem_unsigned(funct3);
    rbyte     = rword[{addr_lo, 3'b000} +: 8];
    rhalf     = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (size)
      SZ_BYTE: begin
        byte_en   = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = uns ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
      end
      SZ_HALF: begin
        misalign  = addr_lo[0];
        byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = uns ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
      end
      default: begin
        misalign  = (addr_lo != 2'b00);
        byte_en   = '1;
        wdata_rep = wdata;
        rdata     = rword;
      end
    endcase
  end

endmodule

// File: rtl/dmem_resp.sv
// MEM-stage data-memory responder: services loads/stores with a fixed number
// of wait states, stalling the pipeline while the access is in flight.
module dmem_resp
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwritem,
  input  logic [1:0]  resultsrcm,
  input  logic [2:0]  funct3m,
  input  logic [31:0] aluresultm,
  input  logic [31:0] writedatam,
  output logic [31:0] readdatam,
  output logic        stallm,
  output logic        misalignm
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  dmem_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic          req;
  logic          is_load;
  logic          stall;
  logic          done;
  logic          live;
  logic          commit;
  logic [AW-1:0] widx;
  logic [31:0]   rword;
  logic [3:0]    byte_en;
  logic [31:0]   wdata_rep;
  logic [31:0]   rdata_ext;
  logic          mis_a;
  logic          unused_addr_hi;

  // A simultaneous store and load is treated as a store.
  assign is_load        = (resultsrcm == RESULTSRC_MEM) && !memwritem;
  assign req            = memwritem || (resultsrcm == RESULTSRC_MEM);
  assign widx           = aluresultm[AW+1:2];
  assign rword          = mem_q[widx];
  assign unused_addr_hi = ^aluresultm[31:AW+2];

  dmem_lane_align u_align (
    .funct3    (funct3m),
    .addr_lo   (aluresultm[1:0]),
    .wdata     (writedatam),
    .rword     (rword),
    .byte_en   (byte_en),
    .wdata_rep (wdata_rep),
    .rdata     (rdata_ext),
    .misalign  (mis_a)
  );

  // Next-state, counter and stall/done decode.
  // cnt holds the number of stall cycles already spent (the IDLE request
  // cycle counts as the first), so DONE is entered once it reaches
  // WAIT_CYCLES; this keeps stallm high for exactly WAIT_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    done    = 1'b0;
    case (state_q)
      DMEM_IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            done = 1'b1;
          end else begin
            stall   = 1'b1;
            cnt_d   = CNT_W'(1);
            state_d = (WAIT_CYCLES == 1) ? DMEM_DONE : DMEM_WAIT;
          end
        end
      end
      DMEM_WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (32'(cnt_d) == WAIT_CYCLES) begin
          state_d = DMEM_DONE;
        end
      end
      DMEM_DONE: begin
        done    = 1'b1;
        cnt_d   = '0;
        state_d = DMEM_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = DMEM_IDLE;
      end
    endcase
  end

  // Outputs are forced quiet while reset is asserted.
  always_comb begin
    live      = done && req && !reset;
    commit    = done && memwritem && !mis_a && !reset;
    stallm    = stall && !reset;
    misalignm = live && mis_a;
    readdatam = (live && is_load && !mis_a) ? rdata_ext : '0;
  end

  // FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DMEM_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Store commit at the edge ending the done cycle; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byte_en[i]) begin
          mem_q[widx][8*i +: 8] <= wdata_rep[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Self-checking bench for dmem_resp: one instance with two wait states and
// one single-cycle instance share the stimulus; each scenario task checks
// the instance it targets against a scoreboard of expected results.
module tb_dmem_resp;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwritem;
  logic [1:0]  resultsrcm;
  logic [2:0]  funct3m;
  logic [31:0] aluresultm;
  logic [31:0] writedatam;
  logic [31:0] rd2, rd0;
  logic        st2, st0, mis2, mis0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .reset(reset), .memwritem(memwritem), .resultsrcm(resultsrcm),
    .funct3m(funct3m), .aluresultm(aluresultm), .writedatam(writedatam),
    .readdatam(rd2), .stallm(st2), .misalignm(mis2)
  );

  dmem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset(reset), .memwritem(memwritem), .resultsrcm(resultsrcm),
    .funct3m(funct3m), .aluresultm(aluresultm), .writedatam(writedatam),
    .readdatam(rd0), .stallm(st0), .misalignm(mis0)
  );

  typedef struct {
    logic        we;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        mis;
  } op_t;

  op_t sb[$];

  function automatic op_t mk_st(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic mis);
    op_t o;
    o.we = 1'b1; o.rs = 2'b00; o.f3 = f3; o.addr = addr; o.wd = wd; o.rd = '0; o.mis = mis;
    return o;
  endfunction

  function automatic op_t mk_ld(input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] rd, input logic mis);
    op_t o;
    o.we = 1'b0; o.rs = 2'b01; o.f3 = f3; o.addr = addr; o.wd = 32'h5A5A_5A5A; o.rd = rd; o.mis = mis;
    return o;
  endfunction

  // Drives one access (entered just after a rising edge), records its
  // expectation, and waits for the done cycle of the selected instance.
  task automatic run_op(input bit sel, input op_t op, output logic [31:0] rd,
                        output logic mis, output int stalls, output bit bad_idle,
                        output bit timeout);
    stalls = 0; bad_idle = 1'b0; timeout = 1'b1; rd = '0; mis = 1'b0;
    sb.push_back(op);
    memwritem = op.we; resultsrcm = op.rs; funct3m = op.f3;
    aluresultm = op.addr; writedatam = op.wd;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (sel ? st2 : st0) begin
        stalls++;
        if ((sel ? rd2 : rd0) !== 32'h0 || (sel ? mis2 : mis0) !== 1'b0) bad_idle = 1'b1;
        @(posedge clk); #1;
      end else begin
        rd = sel ? rd2 : rd0;
        mis = sel ? mis2 : mis0;
        timeout = 1'b0;
        break;
      end
    end
    @(posedge clk); #1;
    memwritem = 1'b0; resultsrcm = 2'b00;
  endtask

  task automatic test_reset();
    reset = 1'b1; memwritem = 1'b0; resultsrcm = 2'b00; funct3m = LW;
    aluresultm = '0; writedatam = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    n_checks++; if (st2 !== 1'b0) begin n_fail++; $display("FAIL reset_stall2: got %b, want 0", st2); end
    n_checks++; if (st0 !== 1'b0) begin n_fail++; $display("FAIL reset_stall0: got %b, want 0", st0); end
    n_checks++; if (rd2 !== 32'h0 || rd0 !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h/%h, want 0", rd2, rd0); end
    n_checks++; if (mis2 !== 1'b0 || mis0 !== 1'b0) begin n_fail++; $display("FAIL reset_misalign: got %b/%b, want 0", mis2, mis0); end
    @(posedge clk); #1;
  endtask

  task automatic test_store_load();
    op_t tbl[$];
    op_t e;
    logic [31:0] rd; logic mis; int st; bit bi, to;
    tbl.push_back(mk_st(LW, 32'h10, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h10, 32'hDEAD_BEEF, 1'b0));
    tbl.push_back(mk_ld(LB, 32'h13, 32'hFFFF_FFDE, 1'b0));
    tbl.push_back(mk_ld(LBU, 32'h13, 32'h0000_00DE, 1'b0));
    tbl.push_back(mk_ld(LH, 32'h12, 32'hFFFF_DEAD, 1'b0));
    tbl.push_back(mk_ld(LHU, 32'h12, 32'h0000_DEAD, 1'b0));
    tbl.push_back(mk_ld(LB, 32'h10, 32'hFFFF_FFEF, 1'b0));
    tbl.push_back(mk_ld(LBU, 32'h11, 32'h0000_00BE, 1'b0));
    tbl.push_back(mk_st(LB, 32'h11, 32'hFFFF_FFA5, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h10, 32'hDEAD_A5EF, 1'b0));
    tbl.push_back(mk_st(LH, 32'h12, 32'hABCD_1234, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h10, 32'h1234_A5EF, 1'b0));
    tbl.push_back(mk_st(3'b011, 32'h14, 32'h0102_0304, 1'b0));
    tbl.push_back(mk_ld(3'b111, 32'h14, 32'h0102_0304, 1'b0));
    tbl.push_back(mk_ld(3'b110, 32'h14, 32'h0102_0304, 1'b0));
    foreach (tbl[i]) begin
      run_op(1'b1, tbl[i], rd, mis, st, bi, to);
      e = sb.pop_front();
      n_checks++;
      if (to || rd !== e.rd || mis !== e.mis) begin
        n_fail++;
        $display("FAIL store_load[%0d]: rd=%h mis=%b timeout=%b, want rd=%h mis=%b", i, rd, mis, to, e.rd, e.mis);
      end
      n_checks++;
      if (st != 2 || bi) begin
        n_fail++;
        $display("FAIL store_load_stall[%0d]: stalls=%0d noisy=%b, want 2 quiet", i, st, bi);
      end
    end
  endtask

  task automatic test_misalign();
    op_t tbl[$];
    op_t e;
    logic [31:0] rd; logic mis; int st; bit bi, to;
    tbl.push_back(mk_st(LH, 32'h11, 32'h0000_1234, 1'b1));
    tbl.push_back(mk_ld(LW, 32'h10, 32'h1234_A5EF, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h12, 32'h0, 1'b1));
    tbl.push_back(mk_ld(LH, 32'h13, 32'h0, 1'b1));
    tbl.push_back(mk_st(LW, 32'h12, 32'hFFFF_FFFF, 1'b1));
    tbl.push_back(mk_ld(LW, 32'h10, 32'h1234_A5EF, 1'b0));
    foreach (tbl[i]) begin
      run_op(1'b1, tbl[i], rd, mis, st, bi, to);
      e = sb.pop_front();
      n_checks++;
      if (to || rd !== e.rd || mis !== e.mis) begin
        n_fail++;
        $display("FAIL misalign[%0d]: rd=%h mis=%b timeout=%b, want rd=%h mis=%b", i, rd, mis, to, e.rd, e.mis);
      end
      n_checks++;
      if (st != 2 || bi) begin
        n_fail++;
        $display("FAIL misalign_stall[%0d]: stalls=%0d noisy=%b, want 2 quiet", i, st, bi);
      end
    end
  endtask

  task automatic test_reset_abort();
    op_t e;
    logic [31:0] rd; logic mis; int st; bit bi, to;
    run_op(1'b1, mk_st(LW, 32'h20, 32'h1111_1111, 1'b0), rd, mis, st, bi, to);
    e = sb.pop_front();
    n_checks++;
    if (to || st != 2) begin n_fail++; $display("FAIL abort_setup: stalls=%0d timeout=%b, want 2 0", st, to); end
    memwritem = 1'b1; resultsrcm = 2'b00; funct3m = LW;
    aluresultm = 32'h20; writedatam = 32'h0000_0055;
    @(negedge clk);
    n_checks++;
    if (st2 !== 1'b1) begin n_fail++; $display("FAIL abort_first_stall: got %b, want 1", st2); end
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0; memwritem = 1'b0;
    @(negedge clk);
    n_checks++;
    if (st2 !== 1'b0 || mis2 !== 1'b0 || rd2 !== 32'h0) begin
      n_fail++; $display("FAIL abort_quiet: stall=%b mis=%b rd=%h, want 0 0 0", st2, mis2, rd2);
    end
    @(posedge clk); #1;
    run_op(1'b1, mk_ld(LW, 32'h20, 32'h1111_1111, 1'b0), rd, mis, st, bi, to);
    e = sb.pop_front();
    n_checks++;
    if (to || rd !== e.rd || st != 2) begin
      n_fail++; $display("FAIL abort_no_commit: rd=%h stalls=%0d, want rd=%h stalls=2", rd, st, e.rd);
    end
  endtask

  task automatic test_alias();
    op_t tbl[$];
    op_t e;
    logic [31:0] rd; logic mis; int st; bit bi, to;
    tbl.push_back(mk_st(LW, 32'h1000, 32'hCAFE_F00D, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h0, 32'hCAFE_F00D, 1'b0));
    tbl.push_back(mk_ld(LW, 32'hFFFF_F000, 32'hCAFE_F00D, 1'b0));
    tbl.push_back(mk_st(LB, 32'h0, 32'h0000_0077, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h1000, 32'hCAFE_F077, 1'b0));
    foreach (tbl[i]) begin
      run_op(1'b1, tbl[i], rd, mis, st, bi, to);
      e = sb.pop_front();
      n_checks++;
      if (to || rd !== e.rd || mis !== e.mis || st != 2) begin
        n_fail++;
        $display("FAIL alias[%0d]: rd=%h mis=%b stalls=%0d, want rd=%h mis=%b stalls=2", i, rd, mis, st, e.rd, e.mis);
      end
    end
  endtask

  task automatic test_back_to_back_wait0();
    op_t tbl[$];
    op_t e;
    logic [31:0] rd; logic mis; int st; bit bi, to;
    tbl.push_back(mk_st(LW, 32'h40, 32'h0BAD_F00D, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h40, 32'h0BAD_F00D, 1'b0));
    tbl.push_back(mk_ld(LB, 32'h43, 32'h0000_000B, 1'b0));
    tbl.push_back(mk_st(LH, 32'h42, 32'h0000_BEEF, 1'b0));
    tbl.push_back(mk_ld(LW, 32'h40, 32'hBEEF_F00D, 1'b0));
    tbl.push_back(mk_ld(LH, 32'h42, 32'hFFFF_BEEF, 1'b0));
    tbl.push_back(mk_st(LW, 32'h41, 32'h0, 1'b1));
    tbl.push_back(mk_ld(LW, 32'h40, 32'hBEEF_F00D, 1'b0));
    foreach (tbl[i]) begin
      run_op(1'b0, tbl[i], rd, mis, st, bi, to);
      e = sb.pop_front();
      n_checks++;
      if (to || rd !== e.rd || mis !== e.mis) begin
        n_fail++;
        $display("FAIL wait0[%0d]: rd=%h mis=%b timeout=%b, want rd=%h mis=%b", i, rd, mis, to, e.rd, e.mis);
      end
      n_checks++;
      if (st != 0) begin
        n_fail++;
        $display("FAIL wait0_stall[%0d]: stalls=%0d, want 0", i, st);
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misalign();
    test_reset_abort();
    test_alias();
    test_back_to_back_wait0();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
